sub_dispatcher: RTL and testbench
=================================

// Module: sub_dispatcher
// PURPOSE
//  Schedules parallel tasks from the main core onto N_SUB sub cores. Queues requested start PCs.
//  Launches each one on an idle sub core with a one-cycle exec_requested pulse.
//  Tracks each core's completion through its ended flag and provides a join barrier to the main core.
// PARAMETERS
//  N_SUB       4   number of sub cores controlled (1..8)
//  FIFO_DEPTH  4   pending-PC queue entries (power of 2, >=2)
// PORTS
//  clk               in   1          single clock
//  rst               in   1          synchronous, active-high reset
//  req_valid         in   1          main core offers a task start PC
//  req_ready         out  1          dispatcher accepts it; transfer when valid&ready at posedge
//  req_pc            in   32         task start PC
//  join_req          in   1          level; main core waits for all tasks to finish
//  join_done         out  1          one-cycle pulse: queue empty and every core IDLE
//  sub_exec_req      out  N_SUB      per-core exec_requested pulse
//  sub_pc            out  32         shared requested_pc bus; valid only while a sub_exec_req bit is set
//  sub_ended         in   N_SUB      per-core ended flag
//  busy_mask         out  N_SUB      1 = core LAUNCH or RUN
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1 one cycle after reset release; queue emptied;
//   every core IDLE; rr_ptr=0. Sub cores share rst; mid-operation reset abandons running tasks.
//  Queue: push on req_valid&req_ready. req_ready = !full && !join_pending.
//   When full, push is refused even if a pop happens in the same cycle.
//  Per-core FSM (sub_state_t):
//   IDLE -> LAUNCH when granted; the registered sub_exec_req bit is high for exactly that one cycle.
//   LAUNCH -> RUN unconditionally; sub_ended is ignored in LAUNCH because it still holds the previous task's 1.
//   RUN -> IDLE when sub_ended==1. sub_ended seen in IDLE is ignored (the core drives 0 at reset).
//  Grant: at most one dispatch per cycle, when the queue is non-empty and at least one core is IDLE.
//   The grantee is the first IDLE core at index >= rr_ptr, wrapping modulo N_SUB.
//   On a grant, rr_ptr <= grantee+1 (mod N_SUB), the queue head pops, and sub_pc is registered with the head.
//  Latency: request accepted at edge t -> sub_exec_req high during cycle t+1 at the earliest.
//  A core that ends at edge t may be granted at edge t+1 (state must be IDLE before the grant).
//  Join: join_pending is set while join_req=1.
//   join_done pulses in the first cycle where join_req && queue empty && all cores IDLE.
//   It does not repeat until join_req drops and rises again. No new pushes while join_pending.
//  Simultaneous events are allowed in one cycle: push, pop, one grant and multiple RUN->IDLE transitions.
//   Occupancy = count + push - pop.
//  Index and rr_ptr are $clog2(N_SUB) bits; occupancy count is $clog2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  SUB_DISPATCH_STATS_EN defined: adds outputs stat_launches[31:0] (grants)
//   and stat_stall[31:0] (cycles with a non-empty queue and no IDLE core).
//   Both are reset to 0 and saturate at 32'hFFFF_FFFF.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package sub_pkg: typedef enum logic[1:0] sub_state_t {IDLE, LAUNCH, RUN};
//   localparam default N_SUB and FIFO_DEPTH.
//  Sub-module pc_fifo: synchronous FIFO with push/pop/full/empty/head.
//   The dispatcher holds the per-core FSMs, the round-robin grant and the join logic.
// TESTING
//  1 Reset, push 0x100 -> sub_exec_req=4'b0001 for 1 cycle with sub_pc=0x100; busy_mask=0001.
//  2 Push 6 PCs back to back, no core ends -> 4 grants to cores 0,1,2,3;
//    2 PCs stay queued; stall counter increments (stats build).
//  3 Queue full, cores busy -> req_ready=0 and a 5th push is held.
//    Pulse sub_ended[2] -> next grant goes to core 2, and req_ready=1 the cycle after the pop.
//  4 join_req with 2 cores RUN -> join_done stays 0 and req_ready=0.
//    Both end -> single join_done pulse; it stays 0 while join_req is held.
//  5 sub_ended=1 stale during LAUNCH -> core stays RUN; it returns to IDLE only on a later sub_ended.
//  6 rst asserted mid-RUN with 3 queued -> next cycle all outputs 0, queue empty, busy_mask=0.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and default sizing for the sub-core dispatcher.
// Per-core lifecycle states and the default core/queue counts.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN
  } sub_state_t;

  localparam int N_SUB_DEFAULT      = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sub_dispatcher_if.sv
// Task-request handshake from the main core to the dispatcher.
// The main core is the master; the dispatcher is the slave.
interface sub_dispatcher_if;
  import sub_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;

  modport master (
    output req_valid,
    output req_pc,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    output req_ready
  );

endinterface

// File: rtl/sub_dispatcher_pc_fifo.sv
// Pending start-PC queue for the dispatcher.
// Synchronous FIFO; push is dropped when full, pop is dropped when empty.
module pc_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/sub_dispatcher.sv
// Dispatches queued task PCs round-robin onto idle sub cores, with join.
// Optional SUB_DISPATCH_STATS_EN adds launch and stall counters.
module sub_dispatcher
  import sub_pkg::*;
#(
  parameter int N_SUB      = N_SUB_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  sub_dispatcher_if.slave  req,
  input  logic             join_req,
  output logic             join_done,
  output logic [N_SUB-1:0] sub_exec_req,
  output logic [31:0]      sub_pc,
  input  logic [N_SUB-1:0] sub_ended,
`ifdef SUB_DISPATCH_STATS_EN
  output logic [31:0]      stat_launches,
  output logic [31:0]      stat_stall,
`endif
  output logic [N_SUB-1:0] busy_mask
);

  localparam int IW = (N_SUB > 1) ? $clog2(N_SUB) : 1;

  sub_state_t state_q [N_SUB];
  sub_state_t state_d [N_SUB];

  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;
  logic             found;
  logic             grant_en;
  logic [N_SUB-1:0] idle;
  logic             all_idle;
  logic             q_full;
  logic             q_empty;
  logic [31:0]      q_head;
  logic             push;
  logic             join_pending;
  logic             join_cond;
  logic             join_seen_q;

  assign join_pending  = join_req;
  assign req.req_ready = !q_full && !join_pending;
  assign push          = req.req_valid && req.req_ready;

  pc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (grant_en),
    .din   (req.req_pc),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    for (int i = 0; i < N_SUB; i++) begin
      idle[i]         = (state_q[i] == IDLE);
      busy_mask[i]    = !idle[i];
      sub_exec_req[i] = (state_q[i] == LAUNCH);
    end
  end

  assign all_idle = &idle;

  // first idle core at or after rr_ptr, wrapping
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_SUB; k++) begin
      if (int'(rr_ptr_q) + k >= N_SUB)
        cand = IW'(int'(rr_ptr_q) + k - N_SUB);
      else
        cand = IW'(int'(rr_ptr_q) + k);
      if (!found && idle[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_en = found && !q_empty;

  always_comb begin
    for (int i = 0; i < N_SUB; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE:
          if (grant_en && grant_idx == IW'(i))
            state_d[i] = LAUNCH;
        LAUNCH:
          state_d[i] = RUN;
        RUN:
          if (sub_ended[i])
            state_d[i] = IDLE;
        default:
          state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SUB; i++)
        state_q[i] <= IDLE;
      rr_ptr_q <= '0;
      sub_pc   <= '0;
    end else begin
      for (int i = 0; i < N_SUB; i++)
        state_q[i] <= state_d[i];
      if (grant_en) begin
        sub_pc <= q_head;
        if (grant_idx == IW'(N_SUB - 1))
          rr_ptr_q <= '0;
        else
          rr_ptr_q <= grant_idx + IW'(1);
      end
    end
  end

  // one pulse per join_req assertion
  assign join_cond = join_req && q_empty && all_idle;
  assign join_done = join_cond && !join_seen_q;

  always_ff @(posedge clk) begin
    if (rst)
      join_seen_q <= 1'b0;
    else
      join_seen_q <= join_req && (join_seen_q || join_cond);
  end

`ifdef SUB_DISPATCH_STATS_EN
  logic [31:0] launches_q;
  logic [31:0] stall_q;

  assign stat_launches = launches_q;
  assign stat_stall    = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      launches_q <= '0;
      stall_q    <= '0;
    end else begin
      if (grant_en && launches_q != '1)
        launches_q <= launches_q + 32'd1;
      if (!q_empty && !(|idle) && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_dispatcher.sv
// Directed self-checking bench for sub_dispatcher.
// Inputs change and outputs are sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_sub_dispatcher;
  import sub_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       join_req = 1'b0;
  logic       join_done;
  logic [3:0] sub_exec_req;
  logic [31:0] sub_pc;
  logic [3:0] sub_ended = 4'b0;
  logic [3:0] busy_mask;
`ifdef SUB_DISPATCH_STATS_EN
  logic [31:0] stat_launches;
  logic [31:0] stat_stall;
`endif

  int total = 0;
  int bad = 0;

  sub_dispatcher_if rq ();

  sub_dispatcher #(.N_SUB(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (rq),
    .join_req     (join_req),
    .join_done    (join_done),
    .sub_exec_req (sub_exec_req),
    .sub_pc       (sub_pc),
    .sub_ended    (sub_ended),
`ifdef SUB_DISPATCH_STATS_EN
    .stat_launches(stat_launches),
    .stat_stall   (stat_stall),
`endif
    .busy_mask    (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq.req_valid = 1'b0;
    rq.req_pc = 32'h0;
    join_req = 1'b0;
    sub_ended = 4'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rq.req_valid = 1'b0;
    rq.req_pc = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    total++; if (sub_exec_req !== 4'b0) begin bad++; $display("FAIL rst_exec got=%b exp=0000", sub_exec_req); end
    total++; if (busy_mask !== 4'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0000", busy_mask); end
    total++; if (sub_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", sub_pc); end
    total++; if (join_done !== 1'b0) begin bad++; $display("FAIL rst_join got=%b exp=0", join_done); end
`ifdef SUB_DISPATCH_STATS_EN
    total++; if (stat_launches !== 32'h0) begin bad++; $display("FAIL rst_launch got=%0d exp=0", stat_launches); end
`endif
    rst = 1'b0;
    tick();
    total++; if (rq.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", rq.req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    rq.req_valid = 1'b1;
    rq.req_pc = 32'h100;
    tick();
    rq.req_valid = 1'b0;
    total++; if (sub_exec_req !== 4'b0) begin bad++; $display("FAIL t1_early got=%b exp=0000", sub_exec_req); end
    tick();
    total++; if (sub_exec_req !== 4'b0001) begin bad++; $display("FAIL t1_exec got=%b exp=0001", sub_exec_req); end
    total++; if (sub_pc !== 32'h100) begin bad++; $display("FAIL t1_pc got=%h exp=100", sub_pc); end
    total++; if (busy_mask !== 4'b0001) begin bad++; $display("FAIL t1_busy got=%b exp=0001", busy_mask); end
    tick();
    total++; if (sub_exec_req !== 4'b0) begin bad++; $display("FAIL t1_pulse got=%b exp=0000", sub_exec_req); end
    total++; if (busy_mask !== 4'b0001) begin bad++; $display("FAIL t1_run got=%b exp=0001", busy_mask); end
    sub_ended = 4'b0001;
    tick();
    sub_ended = 4'b0;
    total++; if (busy_mask !== 4'b0) begin bad++; $display("FAIL t1_end got=%b exp=0000", busy_mask); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_req [6];
    logic [31:0] exp_pc  [6];
    exp_req = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    exp_pc  = '{32'h0, 32'h200, 32'h204, 32'h208, 32'h20C, 32'h0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rq.req_valid = 1'b1;
      rq.req_pc = 32'h200 + 32'(4 * k);
      tick();
      total++; if (sub_exec_req !== exp_req[k]) begin bad++; $display("FAIL t2_exec%0d got=%b exp=%b", k, sub_exec_req, exp_req[k]); end
      if (exp_req[k] != 4'b0) begin
        total++; if (sub_pc !== exp_pc[k]) begin bad++; $display("FAIL t2_pc%0d got=%h exp=%h", k, sub_pc, exp_pc[k]); end
      end
    end
    rq.req_valid = 1'b0;
    total++; if (busy_mask !== 4'b1111) begin bad++; $display("FAIL t2_busy got=%b exp=1111", busy_mask); end
    total++; if (rq.req_ready !== 1'b1) begin bad++; $display("FAIL t2_ready got=%b exp=1", rq.req_ready); end
`ifdef SUB_DISPATCH_STATS_EN
    total++; if (stat_launches !== 32'd4) begin bad++; $display("FAIL t2_launch got=%0d exp=4", stat_launches); end
    total++; if (stat_stall !== 32'd1) begin bad++; $display("FAIL t2_stall got=%0d exp=1", stat_stall); end
`endif
  endtask

  task automatic test_full();
    rq.req_valid = 1'b1;
    rq.req_pc = 32'h218;
    tick();
    rq.req_pc = 32'h21C;
    tick();
    rq.req_pc = 32'h220;
    total++; if (rq.req_ready !== 1'b0) begin bad++; $display("FAIL t3_full got=%b exp=0", rq.req_ready); end
    tick();
    total++; if (rq.req_ready !== 1'b0) begin bad++; $display("FAIL t3_hold got=%b exp=0", rq.req_ready); end
    sub_ended = 4'b0100;
    tick();
    sub_ended = 4'b0;
    total++; if (busy_mask !== 4'b1011) begin bad++; $display("FAIL t3_busy got=%b exp=1011", busy_mask); end
    total++; if (rq.req_ready !== 1'b0) begin bad++; $display("FAIL t3_still got=%b exp=0", rq.req_ready); end
    tick();
    total++; if (sub_exec_req !== 4'b0100) begin bad++; $display("FAIL t3_grant got=%b exp=0100", sub_exec_req); end
    total++; if (sub_pc !== 32'h210) begin bad++; $display("FAIL t3_pc got=%h exp=210", sub_pc); end
    total++; if (rq.req_ready !== 1'b1) begin bad++; $display("FAIL t3_ready got=%b exp=1", rq.req_ready); end
    tick();
    rq.req_valid = 1'b0;
    total++; if (rq.req_ready !== 1'b0) begin bad++; $display("FAIL t3_refill got=%b exp=0", rq.req_ready); end
  endtask

  task automatic test_join();
    int pulses;
    do_reset();
    rq.req_valid = 1'b1;
    rq.req_pc = 32'h300;
    tick();
    rq.req_pc = 32'h304;
    tick();
    rq.req_valid = 1'b0;
    tick();
    tick();
    total++; if (busy_mask !== 4'b0011) begin bad++; $display("FAIL t4_busy got=%b exp=0011", busy_mask); end
    join_req = 1'b1;
    #1;
    total++; if (rq.req_ready !== 1'b0) begin bad++; $display("FAIL t4_ready got=%b exp=0", rq.req_ready); end
    total++; if (join_done !== 1'b0) begin bad++; $display("FAIL t4_early got=%b exp=0", join_done); end
    sub_ended = 4'b0001;
    tick();
    total++; if (join_done !== 1'b0) begin bad++; $display("FAIL t4_one got=%b exp=0", join_done); end
    sub_ended = 4'b0010;
    tick();
    sub_ended = 4'b0;
    total++; if (join_done !== 1'b1) begin bad++; $display("FAIL t4_done got=%b exp=1", join_done); end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (join_done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL t4_repeat got=%0d exp=0", pulses); end
    total++; if (rq.req_ready !== 1'b0) begin bad++; $display("FAIL t4_held got=%b exp=0", rq.req_ready); end
    join_req = 1'b0;
    #1;
    total++; if (rq.req_ready !== 1'b1) begin bad++; $display("FAIL t4_release got=%b exp=1", rq.req_ready); end
    tick();
    join_req = 1'b1;
    #1;
    total++; if (join_done !== 1'b1) begin bad++; $display("FAIL t4_rearm got=%b exp=1", join_done); end
    tick();
    join_req = 1'b0;
  endtask

  task automatic test_stale_end();
    do_reset();
    sub_ended = 4'b0001;
    rq.req_valid = 1'b1;
    rq.req_pc = 32'h400;
    tick();
    rq.req_valid = 1'b0;
    tick();
    total++; if (sub_exec_req !== 4'b0001) begin bad++; $display("FAIL t5_launch got=%b exp=0001", sub_exec_req); end
    tick();
    sub_ended = 4'b0;
    total++; if (busy_mask !== 4'b0001) begin bad++; $display("FAIL t5_run got=%b exp=0001", busy_mask); end
    tick();
    tick();
    total++; if (busy_mask !== 4'b0001) begin bad++; $display("FAIL t5_stay got=%b exp=0001", busy_mask); end
    sub_ended = 4'b0001;
    tick();
    sub_ended = 4'b0;
    total++; if (busy_mask !== 4'b0) begin bad++; $display("FAIL t5_idle got=%b exp=0000", busy_mask); end
  endtask

  task automatic test_mid_reset();
    int grants;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      rq.req_valid = 1'b1;
      rq.req_pc = 32'h600 + 32'(4 * k);
      tick();
    end
    rq.req_valid = 1'b0;
    total++; if (busy_mask !== 4'b1111) begin bad++; $display("FAIL t6_pre got=%b exp=1111", busy_mask); end
    rst = 1'b1;
    tick();
    total++; if (busy_mask !== 4'b0) begin bad++; $display("FAIL t6_busy got=%b exp=0000", busy_mask); end
    total++; if (sub_exec_req !== 4'b0) begin bad++; $display("FAIL t6_exec got=%b exp=0000", sub_exec_req); end
    total++; if (sub_pc !== 32'h0) begin bad++; $display("FAIL t6_pc got=%h exp=0", sub_pc); end
    rst = 1'b0;
    grants = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (sub_exec_req !== 4'b0) grants++;
    end
    total++; if (grants !== 0) begin bad++; $display("FAIL t6_empty got=%0d exp=0", grants); end
    rq.req_valid = 1'b1;
    rq.req_pc = 32'h500;
    tick();
    rq.req_valid = 1'b0;
    tick();
    total++; if (sub_exec_req !== 4'b0001) begin bad++; $display("FAIL t6_next got=%b exp=0001", sub_exec_req); end
    total++; if (sub_pc !== 32'h500) begin bad++; $display("FAIL t6_npc got=%h exp=500", sub_pc); end
  endtask

  initial begin
    rq.req_valid = 1'b0;
    rq.req_pc = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_join();
    test_stale_end();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
